// File: rtl/multi_channel_counter.sv
// Per-channel saturating push counters with last-word capture, a saturating grand total and
// a req/idx readback port. Optional clear-on-read behaviour is enabled by COUNTER_CLEAR_ON_READ_EN.
module mcc_lane #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  clr,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [CNT_WIDTH-1:0]  cnt_nxt,
    output logic [DATA_WIDTH-1:0] last_nxt
);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] last_q, last_d;

    // cnt_nxt/last_nxt are this cycle's post-push values, which is what a snapshot reports
    always_comb begin
        cnt_nxt = cnt_q;
        if (push && cnt_q != CNT_MAX) cnt_nxt = cnt_q + 1'b1;
        cnt_d    = clr ? CNT_WIDTH'(push) : cnt_nxt;
        last_d   = push ? data_in : last_q;
        last_nxt = last_d;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q  <= '0;
            last_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            last_q <= last_d;
        end
    end
endmodule

module multi_channel_counter #(
    parameter int DATA_WIDTH = 8,
    parameter int CHANNELS   = 4,
    parameter int IDX_WIDTH  = 2,
    parameter int CNT_WIDTH  = 5
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [CHANNELS-1:0]            push,
    input  logic [CHANNELS*DATA_WIDTH-1:0] data_in,
    input  logic                           req,
    input  logic [IDX_WIDTH-1:0]           idx,
    output logic                           valid_cont,
    output logic [CNT_WIDTH-1:0]           data_cont,
    output logic [DATA_WIDTH-1:0]          data_ant,
    output logic [CNT_WIDTH+IDX_WIDTH-1:0] cont
);
    localparam int TOT_W = CNT_WIDTH + IDX_WIDTH;
    localparam logic [TOT_W-1:0] TOT_MAX = '1;

    typedef enum logic {COUNT, REPORT} state_t;

    logic [CHANNELS-1:0][CNT_WIDTH-1:0]  lane_cnt;
    logic [CHANNELS-1:0][DATA_WIDTH-1:0] lane_last;
    logic [CHANNELS-1:0]                 lane_clr;

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  snap_cnt_q, snap_cnt_d;
    logic [DATA_WIDTH-1:0] snap_last_q, snap_last_d;
    logic                  valid_q, valid_d;
    logic [CNT_WIDTH-1:0]  data_cont_q, data_cont_d;
    logic [DATA_WIDTH-1:0] data_ant_q, data_ant_d;
    logic [TOT_W-1:0]      cont_q, cont_d;

    logic                  sel_ok;
    logic [CNT_WIDTH-1:0]  sel_cnt;
    logic [DATA_WIDTH-1:0] sel_last;
    logic                  take;
    logic [TOT_W:0]        pop;
    logic [TOT_W:0]        cont_sum;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        mcc_lane #(
            .DATA_WIDTH(DATA_WIDTH),
            .CNT_WIDTH (CNT_WIDTH)
        ) u_lane (
            .clk     (clk),
            .reset   (reset),
            .push    (push[i]),
            .clr     (lane_clr[i]),
            .data_in (data_in[i*DATA_WIDTH +: DATA_WIDTH]),
            .cnt_nxt (lane_cnt[i]),
            .last_nxt(lane_last[i])
        );
    end

    // Explicit compare loop keeps out-of-range idx from selecting a non-existent lane
    always_comb begin
        sel_ok   = 1'b0;
        sel_cnt  = '0;
        sel_last = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (idx == IDX_WIDTH'(i)) begin
                sel_ok   = 1'b1;
                sel_cnt  = lane_cnt[i];
                sel_last = lane_last[i];
            end
        end
    end

    assign take = (state_q == COUNT) && req && sel_ok;

    always_comb begin
        lane_clr = '0;
`ifdef COUNTER_CLEAR_ON_READ_EN
        for (int i = 0; i < CHANNELS; i++)
            lane_clr[i] = take && (idx == IDX_WIDTH'(i));
`endif
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < CHANNELS; i++) pop = pop + (TOT_W+1)'(push[i]);
        cont_sum = {1'b0, cont_q} + pop;
        cont_d   = cont_sum[TOT_W] ? TOT_MAX : cont_sum[TOT_W-1:0];
    end

    // Snapshot lands in snap_* at the req edge and moves to the outputs one edge later,
    // so data_cont/data_ant only change together with valid_cont.
    always_comb begin
        state_d     = state_q;
        snap_cnt_d  = snap_cnt_q;
        snap_last_d = snap_last_q;
        valid_d     = 1'b0;
        data_cont_d = data_cont_q;
        data_ant_d  = data_ant_q;
        case (state_q)
            COUNT: begin
                if (take) begin
                    state_d     = REPORT;
                    snap_cnt_d  = sel_cnt;
                    snap_last_d = sel_last;
                end
            end
            REPORT: begin
                state_d     = COUNT;
                valid_d     = 1'b1;
                data_cont_d = snap_cnt_q;
                data_ant_d  = snap_last_q;
            end
            default: state_d = COUNT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= COUNT;
            snap_cnt_q  <= '0;
            snap_last_q <= '0;
            valid_q     <= 1'b0;
            data_cont_q <= '0;
            data_ant_q  <= '0;
            cont_q      <= '0;
        end else begin
            state_q     <= state_d;
            snap_cnt_q  <= snap_cnt_d;
            snap_last_q <= snap_last_d;
            valid_q     <= valid_d;
            data_cont_q <= data_cont_d;
            data_ant_q  <= data_ant_d;
            cont_q      <= cont_d;
        end
    end

    assign valid_cont = valid_q;
    assign data_cont  = data_cont_q;
    assign data_ant   = data_ant_q;
    assign cont       = cont_q;
endmodule
